weight_mem_ctrl: RTL and testbench
==================================

// Module: weight_mem_ctrl
// PURPOSE
//  Sequencer for the weight memory: streams weight words into it, then sweeps read addresses.
//  Owns both memory ports (write addr/strobe/data, read addr/strobe).
//  Arbitrates load vs read so the memory never sees both phases at once.
//  Sits between the host/weight loader and the PE array weight feed.
// PARAMETERS
//  MEMORY_WIDTH  72  weight word width (bits)
//  ADDRS_WIDTH   8   memory address width; addresses wrap modulo 2**ADDRS_WIDTH
// PORTS
//  clk_i            in   1              clock; all logic on posedge
//  rst_i            in   1              synchronous, active-high reset
//  ld_start_i       in   1              start load phase (sampled in IDLE only)
//  ld_len_i         in   ADDRS_WIDTH+1  words to load, written from address 0
//  ld_data_i        in   MEMORY_WIDTH   weight word
//  ld_valid_i       in   1              ld_data_i valid
//  ld_ready_o       out  1              controller accepts word (high only in LOAD)
//  rd_start_i       in   1              start read sweep (sampled in IDLE only)
//  rd_base_i        in   ADDRS_WIDTH    first read address
//  rd_len_i         in   ADDRS_WIDTH+1  words to read
//  rd_stall_i       in   1              consumer back-pressure; freezes read issue
//  mem_wr_addrs_o   out  ADDRS_WIDTH    memory write address
//  mem_wr_ld_o      out  1              memory write strobe
//  mem_wr_data_o    out  MEMORY_WIDTH   memory write data
//  mem_rd_addrs_o   out  ADDRS_WIDTH    memory read address
//  mem_rd_ld_o      out  1              memory read strobe
//  data_valid_o     out  1              memory output valid this cycle
//  busy_o           out  1              high in any state but IDLE
//  done_o           out  1              1-cycle pulse at end of load or read phase
// BEHAVIOUR
//  Reset: state IDLE; every output 0; pointers/counters 0. Reset mid-phase aborts; no done_o.
//  FSM IDLE->LOAD (ld_start_i, ld_len_i!=0); IDLE->READ (rd_start_i, rd_len_i!=0);
//   LOAD->IDLE after last word; READ->DRAIN after last issue; DRAIN->IDLE after 1 cycle.
//  Both starts in same IDLE cycle: LOAD wins, rd_start_i dropped. Starts outside IDLE ignored.
//  Length 0: start ignored, stay IDLE, no done_o. ld_len/rd_len/rd_base captured at start.
//  LOAD: ld_ready_o=1; each ld_valid_i&&ld_ready_o cycle -> registered write next cycle:
//   mem_wr_ld_o=1, mem_wr_addrs_o=ptr, mem_wr_data_o=ld_data_i; ptr++. 1-cycle write latency.
//   ld_ready_o drops the cycle after last accept; done_o pulses with the last write strobe.
//  READ: each cycle with rd_stall_i=0: mem_rd_ld_o=1, mem_rd_addrs_o=base+i (wraps), i++.
//   rd_stall_i=1: mem_rd_ld_o=0, address held, count unchanged.
//  data_valid_o = mem_rd_ld_o delayed 1 cycle (matches 1-cycle memory read latency).
//  DRAIN: mem_rd_ld_o=0; done_o pulses coinciding with final data_valid_o.
//  len = 2**ADDRS_WIDTH legal: full-depth sweep, wrap lands back on base. Larger values clamp.
//  mem_rd_ld_o and mem_wr_ld_o never high in the same cycle.
// CONFIGURATION
//  WEIGHT_MEM_CTRL_REPEAT_EN defined: extra port rd_repeat_i [7:0], captured at rd_start;
//   sweep runs rd_repeat_i+1 times back-to-back, address restarts at base, no gap cycle;
//   done_o only after final sweep's data.
//  Undefined: port absent; exactly one sweep per rd_start_i.
// STRUCTURE
//  Package weight_mem_ctrl_pkg: FSM state encoding (IDLE, LOAD, READ, DRAIN), width
//   localparams, repeat-count width.
//  Sub-module addr_sweep_counter: base load, enable, wrap-around increment, remaining count,
//   last flag. Instantiated twice: write pointer, read sweep.
// TESTING
//  Reset mid-LOAD after 3 words -> all outputs 0, IDLE next cycle, no done_o.
//  ld_len=4, valid every cycle, words A..D -> writes to addr 0..3, 1-cycle lag;
//   done_o with 4th strobe.
//  rd_base=0xFE, rd_len=4 -> addrs FE,FF,00,01; data_valid_o one cycle after each strobe;
//   done_o on last valid.
//  rd_stall_i high 2 cycles mid-sweep -> strobe low, address held, still 4 strobes total.
//  ld_start_i and rd_start_i same cycle -> LOAD only, no read strobes; rd_len=0 -> no activity.
//  REPEAT_EN, rd_repeat=2, rd_len=3, base 5 -> 5,6,7 three times (9 strobes), one done_o.

Source files
------------

// File: rtl/weight_mem_ctrl_pkg.sv
// Shared types and default widths for the weight memory sequencer.
// Optional build macro: WEIGHT_MEM_CTRL_REPEAT_EN (multi-sweep reads).
package weight_mem_ctrl_pkg;

  localparam int DEF_MEMORY_WIDTH = 72;
  localparam int DEF_ADDRS_WIDTH  = 8;
  localparam int REPEAT_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/weight_mem_ctrl_if.sv
// Host/loader command side plus both weight memory ports of the sequencer.
// WEIGHT_MEM_CTRL_REPEAT_EN adds the rd_repeat_i sweep-count input.
interface weight_mem_ctrl_if
  import weight_mem_ctrl_pkg::*;
#(
  parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
  parameter int ADDRS_WIDTH  = DEF_ADDRS_WIDTH
);
  logic                    ld_start_i;
  logic [ADDRS_WIDTH:0]    ld_len_i;
  logic [MEMORY_WIDTH-1:0] ld_data_i;
  logic                    ld_valid_i;
  logic                    ld_ready_o;
  logic                    rd_start_i;
  logic [ADDRS_WIDTH-1:0]  rd_base_i;
  logic [ADDRS_WIDTH:0]    rd_len_i;
  logic                    rd_stall_i;
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
  logic [REPEAT_W-1:0]     rd_repeat_i;
`endif
  logic [ADDRS_WIDTH-1:0]  mem_wr_addrs_o;
  logic                    mem_wr_ld_o;
  logic [MEMORY_WIDTH-1:0] mem_wr_data_o;
  logic [ADDRS_WIDTH-1:0]  mem_rd_addrs_o;
  logic                    mem_rd_ld_o;
  logic                    data_valid_o;
  logic                    busy_o;
  logic                    done_o;

  modport slave (
    input  ld_start_i, ld_len_i, ld_data_i, ld_valid_i,
    input  rd_start_i, rd_base_i, rd_len_i, rd_stall_i,
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
    input  rd_repeat_i,
`endif
    output ld_ready_o, mem_wr_addrs_o, mem_wr_ld_o, mem_wr_data_o,
    output mem_rd_addrs_o, mem_rd_ld_o, data_valid_o, busy_o, done_o
  );

  modport master (
    output ld_start_i, ld_len_i, ld_data_i, ld_valid_i,
    output rd_start_i, rd_base_i, rd_len_i, rd_stall_i,
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
    output rd_repeat_i,
`endif
    input  ld_ready_o, mem_wr_addrs_o, mem_wr_ld_o, mem_wr_data_o,
    input  mem_rd_addrs_o, mem_rd_ld_o, data_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/weight_mem_ctrl_addr_sweep_counter.sv
// Address sweep counter: loads base/length, steps a wrapping address on enable
// and flags the final address of the sweep.
module addr_sweep_counter
  import weight_mem_ctrl_pkg::*;
#(
  parameter int AW = DEF_ADDRS_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_load,
  input  logic [AW-1:0] i_base,
  input  logic [AW:0]   i_len,
  input  logic          i_en,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  // Full memory depth is the longest legal sweep; longer requests clamp to it.
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_addr;
  logic [AW:0]   r_rem;
  logic [AW:0]   w_len_clamped;

  assign w_len_clamped = (i_len > MAX_LEN) ? MAX_LEN : i_len;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
      r_rem  <= w_len_clamped;
    end else if (i_en) begin
      r_addr <= r_addr + AW'(1);
      r_rem  <= r_rem - (AW+1)'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == (AW+1)'(1));

endmodule

// File: rtl/weight_mem_ctrl.sv
// Weight memory sequencer: streams a load into memory from address 0, or sweeps
// read addresses; the two phases never overlap. Optional: WEIGHT_MEM_CTRL_REPEAT_EN.
module weight_mem_ctrl
  import weight_mem_ctrl_pkg::*;
#(
  parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
  parameter int ADDRS_WIDTH  = DEF_ADDRS_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  weight_mem_ctrl_if.slave bus
);

  state_e r_state, w_state_nxt;

  logic                    w_ld_accept, w_rd_issue;
  logic                    w_wr_load, w_rd_load;
  logic [ADDRS_WIDTH-1:0]  w_rd_base_sel;
  logic [ADDRS_WIDTH:0]    w_rd_len_sel;
  logic [ADDRS_WIDTH-1:0]  w_wr_ptr, w_rd_addr;
  logic                    w_wr_last, w_rd_last;

  logic                    r_wr_ld, r_ld_done, r_rd_vld;
  logic [ADDRS_WIDTH-1:0]  r_wr_addr;
  logic [MEMORY_WIDTH-1:0] r_wr_data;

`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
  logic [REPEAT_W-1:0]     r_rep_left;
  logic [ADDRS_WIDTH-1:0]  r_rd_base;
  logic [ADDRS_WIDTH:0]    r_rd_len;
  logic                    w_rd_reload;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_load     = 1'b0;
    w_rd_load     = 1'b0;
    w_ld_accept   = 1'b0;
    w_rd_issue    = 1'b0;
    w_rd_base_sel = bus.rd_base_i;
    w_rd_len_sel  = bus.rd_len_i;
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
    w_rd_reload   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        // Load has priority; a simultaneous read start is dropped.
        if (bus.ld_start_i && bus.ld_len_i != '0) begin
          w_state_nxt = ST_LOAD;
          w_wr_load   = 1'b1;
        end else if (bus.rd_start_i && bus.rd_len_i != '0) begin
          w_state_nxt = ST_READ;
          w_rd_load   = 1'b1;
        end
      end
      ST_LOAD: begin
        w_ld_accept = bus.ld_valid_i;
        if (bus.ld_valid_i && w_wr_last) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        w_rd_issue = !bus.rd_stall_i;
        if (w_rd_issue && w_rd_last) begin
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
          // Restart at base with no bubble while sweeps remain.
          if (r_rep_left != '0) begin
            w_rd_reload   = 1'b1;
            w_rd_load     = 1'b1;
            w_rd_base_sel = r_rd_base;
            w_rd_len_sel  = r_rd_len;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
`else
          w_state_nxt = ST_DRAIN;
`endif
        end
      end
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  addr_sweep_counter #(.AW(ADDRS_WIDTH)) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_wr_load),
    .i_base ('0),
    .i_len  (bus.ld_len_i),
    .i_en   (w_ld_accept),
    .o_addr (w_wr_ptr),
    .o_last (w_wr_last)
  );

  addr_sweep_counter #(.AW(ADDRS_WIDTH)) u_rd_sweep (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_load (w_rd_load),
    .i_base (w_rd_base_sel),
    .i_len  (w_rd_len_sel),
    .i_en   (w_rd_issue),
    .o_addr (w_rd_addr),
    .o_last (w_rd_last)
  );

`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rep_left <= '0;
      r_rd_base  <= '0;
      r_rd_len   <= '0;
    end else if (r_state == ST_IDLE && w_rd_load) begin
      r_rep_left <= bus.rd_repeat_i;
      r_rd_base  <= bus.rd_base_i;
      r_rd_len   <= bus.rd_len_i;
    end else if (w_rd_reload) begin
      r_rep_left <= r_rep_left - REPEAT_W'(1);
    end
  end
`endif

  // Writes land one cycle after the accept; done marks the final write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ld   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ld_done <= 1'b0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_wr_ld   <= w_ld_accept;
      r_ld_done <= w_ld_accept && w_wr_last;
      r_rd_vld  <= w_rd_issue;
      if (w_ld_accept) begin
        r_wr_addr <= w_wr_ptr;
        r_wr_data <= bus.ld_data_i;
      end
    end
  end

  assign bus.ld_ready_o     = (r_state == ST_LOAD);
  assign bus.busy_o         = (r_state != ST_IDLE);
  assign bus.mem_wr_ld_o    = r_wr_ld;
  assign bus.mem_wr_addrs_o = r_wr_addr;
  assign bus.mem_wr_data_o  = r_wr_data;
  assign bus.mem_rd_ld_o    = w_rd_issue;
  assign bus.mem_rd_addrs_o = w_rd_addr;
  assign bus.data_valid_o   = r_rd_vld;
  assign bus.done_o         = r_ld_done || (r_state == ST_DRAIN);

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Randomized bench for weight_mem_ctrl against a transaction-level reference model.
// Honours WEIGHT_MEM_CTRL_REPEAT_EN when the design is built with it.
module tb_weight_mem_ctrl;

  localparam int MW = 72;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  weight_mem_ctrl_if #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW)) bus ();
  weight_mem_ctrl #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words left to accept, queue of read addresses still to issue.
  int          m_ld_left = 0;
  int          m_ld_addr = 0;
  logic [AW-1:0] m_rd_q[$];
  bit          m_pend_wr = 0, m_wr_last = 0, m_prev_rd = 0, m_drain = 0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [MW-1:0] m_wr_data = '0;

  always @(negedge clk) begin
    bit exp_busy, exp_ready, exp_rd, exp_done, nxt_drain;
    int n, reps;
    if (rst_q) begin
      chk("rst_ready", bus.ld_ready_o, 0);
      chk("rst_wr_ld", bus.mem_wr_ld_o, 0);
      chk("rst_wr_addr", bus.mem_wr_addrs_o, 0);
      chk("rst_wr_data", bus.mem_wr_data_o, 0);
      chk("rst_rd_ld", bus.mem_rd_ld_o, 0);
      chk("rst_rd_addr", bus.mem_rd_addrs_o, 0);
      chk("rst_dvalid", bus.data_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      m_ld_left = 0; m_rd_q.delete(); m_pend_wr = 0; m_wr_last = 0;
      m_prev_rd = 0; m_drain = 0;
    end else begin
      exp_busy  = (m_ld_left > 0) || (m_rd_q.size() > 0) || m_drain;
      exp_ready = (m_ld_left > 0);
      exp_rd    = (m_rd_q.size() > 0) && !bus.rd_stall_i;
      exp_done  = (m_pend_wr && m_wr_last) || m_drain;
      chk("busy", bus.busy_o, exp_busy);
      chk("ld_ready", bus.ld_ready_o, exp_ready);
      chk("wr_ld", bus.mem_wr_ld_o, m_pend_wr);
      if (m_pend_wr) begin
        chk("wr_addr", bus.mem_wr_addrs_o, m_wr_addr);
        chk("wr_data", bus.mem_wr_data_o, m_wr_data);
      end
      chk("rd_ld", bus.mem_rd_ld_o, exp_rd);
      if (m_rd_q.size() > 0) chk("rd_addr", bus.mem_rd_addrs_o, m_rd_q[0]);
      chk("dvalid", bus.data_valid_o, m_prev_rd);
      chk("done", bus.done_o, exp_done);
      chk("rd_wr_excl", bus.mem_rd_ld_o && bus.mem_wr_ld_o, 0);

      nxt_drain = 0;
      if (exp_rd) begin
        void'(m_rd_q.pop_front());
        nxt_drain = (m_rd_q.size() == 0);
      end
      m_prev_rd = exp_rd;
      m_pend_wr = exp_ready && bus.ld_valid_i;
      if (m_pend_wr) begin
        m_wr_addr = AW'(m_ld_addr);
        m_wr_data = bus.ld_data_i;
        m_wr_last = (m_ld_left == 1);
        m_ld_left--;
        m_ld_addr++;
      end
      m_drain = nxt_drain;
      if (!exp_busy) begin
        if (bus.ld_start_i && bus.ld_len_i != 0) begin
          m_ld_left = (int'(bus.ld_len_i) > DEPTH) ? DEPTH : int'(bus.ld_len_i);
          m_ld_addr = 0;
        end else if (bus.rd_start_i && bus.rd_len_i != 0) begin
          n = (int'(bus.rd_len_i) > DEPTH) ? DEPTH : int'(bus.rd_len_i);
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
          reps = int'(bus.rd_repeat_i) + 1;
`else
          reps = 1;
`endif
          for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
              m_rd_q.push_back(AW'((int'(bus.rd_base_i) + i) % DEPTH));
        end
      end
    end
  end

  bit rnd = 0, rnd_st = 0;

  task automatic cyc();
    logic [95:0] t;
    @(posedge clk);
    #1;
    bus.ld_start_i = 1'b0;
    bus.rd_start_i = 1'b0;
    t = {$urandom, $urandom, $urandom};
    bus.ld_data_i = t[MW-1:0];
    if (rnd) begin
      bus.ld_valid_i = 1'($urandom_range(0, 1));
      bus.rd_stall_i = ($urandom_range(0, 3) == 0);
    end
    if (rnd_st && $urandom_range(0, 9) == 0) begin
      bus.ld_start_i = ($urandom_range(0, 2) == 0);
      bus.rd_start_i = ($urandom_range(0, 1) == 0);
      bus.ld_len_i   = (AW+1)'($urandom_range(0, 12));
      bus.rd_len_i   = ($urandom_range(0, 15) == 0) ? (AW+1)'($urandom_range(250, 511))
                                                    : (AW+1)'($urandom_range(0, 12));
      bus.rd_base_i  = AW'($urandom);
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
      bus.rd_repeat_i = 8'($urandom_range(0, 2));
`endif
    end
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int k = 0; k < max; k++) begin
      if (!bus.busy_o && !bus.mem_wr_ld_o && !bus.data_valid_o) begin
        ok = 1;
        break;
      end
      cyc();
    end
    if (!ok) chk("idle_timeout", 0, 1);
    cyc();
  endtask

  initial begin
    bus.ld_start_i = 0; bus.ld_len_i = '0; bus.ld_data_i = '0; bus.ld_valid_i = 0;
    bus.rd_start_i = 0; bus.rd_base_i = '0; bus.rd_len_i = '0; bus.rd_stall_i = 0;
`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
    bus.rd_repeat_i = '0;
`endif
    repeat (3) cyc();
    rst = 0;
    cyc();

    // Load 4 words A..D, valid every cycle.
    bus.ld_start_i = 1; bus.ld_len_i = 4;
    cyc();
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid_i = 1;
      bus.ld_data_i = MW'(72'hA0_0000_0000_0000_0000) + MW'(i);
      cyc();
    end
    bus.ld_valid_i = 0;
    wait_idle(50);

    // Reset in the middle of a load after 3 words.
    bus.ld_start_i = 1; bus.ld_len_i = 10;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid_i = 1;
      cyc();
    end
    bus.ld_valid_i = 0;
    rst = 1;
    cyc();
    rst = 0;
    cyc();
    wait_idle(50);

    // Wrapping read sweep FE,FF,00,01.
    bus.rd_start_i = 1; bus.rd_base_i = 8'hFE; bus.rd_len_i = 4;
    cyc();
    wait_idle(50);

    // Two stall cycles mid-sweep.
    bus.rd_start_i = 1; bus.rd_base_i = 8'h10; bus.rd_len_i = 4;
    cyc();
    cyc();
    bus.rd_stall_i = 1;
    cyc();
    cyc();
    bus.rd_stall_i = 0;
    wait_idle(50);

    // Simultaneous starts: load wins.
    bus.ld_start_i = 1; bus.ld_len_i = 2;
    bus.rd_start_i = 1; bus.rd_base_i = 8'h40; bus.rd_len_i = 3;
    cyc();
    bus.ld_valid_i = 1;
    cyc();
    cyc();
    bus.ld_valid_i = 0;
    wait_idle(50);

    // Zero lengths are ignored.
    bus.ld_start_i = 1; bus.ld_len_i = 0;
    cyc();
    bus.rd_start_i = 1; bus.rd_len_i = 0;
    cyc();
    repeat (3) cyc();

    // Full-depth sweep and a clamped over-length sweep.
    bus.rd_start_i = 1; bus.rd_base_i = 8'h37; bus.rd_len_i = 9'd256;
    cyc();
    wait_idle(400);
    bus.rd_start_i = 1; bus.rd_base_i = 8'h03; bus.rd_len_i = 9'd400;
    cyc();
    wait_idle(400);

`ifdef WEIGHT_MEM_CTRL_REPEAT_EN
    bus.rd_start_i = 1; bus.rd_base_i = 8'h05; bus.rd_len_i = 3; bus.rd_repeat_i = 2;
    cyc();
    wait_idle(50);
    bus.rd_repeat_i = 0;
`endif

    // Clamped load with random valid gaps.
    rnd = 1;
    bus.ld_start_i = 1; bus.ld_len_i = 9'd300;
    cyc();
    wait_idle(2000);

    // Random traffic, starts arriving at arbitrary times.
    rnd_st = 1;
    repeat (4000) cyc();
    rnd_st = 0;
    wait_idle(2000);
    rnd = 0;
    bus.ld_valid_i = 0;
    bus.rd_stall_i = 0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
